// File: rtl/mutex_lock_agent.sv
// Acquires and releases one Avalon hardware mutex for a non-CPU client using
// the write-then-readback lock protocol with fixed backoff and optional retry limit.
module mutex_lock_agent #(
    parameter logic [15:0] OWNER_ID       = 16'h0001,
    parameter logic [15:0] LOCK_VALUE     = 16'h0001,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lock_req,
    input  logic        unlock_req,
    input  logic        abort,
    output logic        granted,
    output logic        busy,
    output logic        lock_fail,
    output logic        unlock_done,
    output logic [7:0]  retry_count,
    output logic        m_address,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOCK_WR,
        LOCK_RD,
        BACKOFF,
        HELD,
        UNLOCK_WR
    } state_t;

    localparam logic [31:0] LOCK_WORD    = {OWNER_ID, LOCK_VALUE};
    localparam logic [31:0] FREE_WORD    = {OWNER_ID, 16'h0000};
    localparam logic [15:0] BACKOFF_LOAD = 16'(BACKOFF_CYCLES - 1);
    localparam logic [8:0]  RETRY_LIMIT  = 9'(MAX_RETRIES);

    state_t      state;
    logic [15:0] backoff_cnt;
    logic        readback_ok;
    logic        limit_hit;

    assign readback_ok = (m_readdata == LOCK_WORD);
    // 9-bit compare so a limit of 255 is reachable without wrapping
    assign limit_hit   = (RETRY_LIMIT != 9'd0) &&
                         (({1'b0, retry_count} + 9'd1) == RETRY_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            backoff_cnt <= '0;
            retry_count <= '0;
            lock_fail   <= 1'b0;
            unlock_done <= 1'b0;
        end else begin
            lock_fail   <= 1'b0;
            unlock_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (lock_req) begin
                        state       <= LOCK_WR;
                        retry_count <= '0;
                    end
                end
                LOCK_WR: begin
                    state <= abort ? IDLE : LOCK_RD;
                end
                LOCK_RD: begin
                    // A matching readback wins over abort so ownership is never orphaned
                    if (readback_ok) begin
                        state <= HELD;
                    end else if (abort) begin
                        state <= IDLE;
                    end else begin
                        if (retry_count != '1) begin
                            retry_count <= retry_count + 8'd1;
                        end
                        if (limit_hit) begin
                            state     <= IDLE;
                            lock_fail <= 1'b1;
                        end else begin
                            state       <= BACKOFF;
                            backoff_cnt <= BACKOFF_LOAD;
                        end
                    end
                end
                BACKOFF: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (backoff_cnt == '0) begin
                        state <= LOCK_WR;
                    end else begin
                        backoff_cnt <= backoff_cnt - 16'd1;
                    end
                end
                HELD: begin
                    if (unlock_req) begin
                        state <= UNLOCK_WR;
                    end
                end
                UNLOCK_WR: begin
                    state       <= IDLE;
                    unlock_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_address = 1'b0;

    always_comb begin
        granted      = 1'b0;
        busy         = 1'b0;
        m_chipselect = 1'b0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_writedata  = '0;
        case (state)
            LOCK_WR: begin
                busy         = 1'b1;
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_writedata  = LOCK_WORD;
            end
            LOCK_RD: begin
                busy         = 1'b1;
                m_chipselect = 1'b1;
                m_read       = 1'b1;
            end
            BACKOFF: busy = 1'b1;
            HELD:    granted = 1'b1;
            UNLOCK_WR: begin
                busy         = 1'b1;
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_writedata  = FREE_WORD;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mutex_lock_agent.sv
// Bench for mutex_lock_agent: two agents against behavioural mutex models, checking
// bus timing and handshake outputs against expectations derived from protocol arithmetic.
module tb_mutex_lock_agent;

    localparam logic [15:0] TB_OWNER      = 16'h0001;
    localparam logic [15:0] TB_LOCK_VALUE = 16'h0001;
    localparam int          A_BACK        = 4;
    localparam int          B_BACK        = 3;
    localparam int          B_MAX         = 2;
    localparam logic [31:0] LOCK_WORD     = 32'h0001_0001;
    localparam logic [31:0] FREE_WORD     = 32'h0001_0000;
    localparam logic [31:0] OTHER_HELD    = 32'h0002_0005;
    localparam logic [31:0] OTHER_FREE    = 32'h0002_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        a_lock, a_unlock, a_abort;
    logic        a_granted, a_busy, a_lock_fail, a_unlock_done;
    logic [7:0]  a_retry;
    logic        a_addr, a_cs, a_rd, a_wr;
    logic [31:0] a_wd, a_rdata, mtx_a;

    logic        b_lock, b_unlock, b_abort;
    logic        b_granted, b_busy, b_lock_fail, b_unlock_done;
    logic [7:0]  b_retry;
    logic        b_addr, b_cs, b_rd, b_wr;
    logic [31:0] b_wd, b_rdata, mtx_b;

    assign a_rdata = mtx_a;
    assign b_rdata = mtx_b;

    mutex_lock_agent #(
        .OWNER_ID(TB_OWNER), .LOCK_VALUE(TB_LOCK_VALUE),
        .BACKOFF_CYCLES(A_BACK), .MAX_RETRIES(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .lock_req(a_lock), .unlock_req(a_unlock),
        .abort(a_abort), .granted(a_granted), .busy(a_busy), .lock_fail(a_lock_fail),
        .unlock_done(a_unlock_done), .retry_count(a_retry), .m_address(a_addr),
        .m_chipselect(a_cs), .m_read(a_rd), .m_write(a_wr), .m_writedata(a_wd),
        .m_readdata(a_rdata)
    );

    mutex_lock_agent #(
        .OWNER_ID(TB_OWNER), .LOCK_VALUE(TB_LOCK_VALUE),
        .BACKOFF_CYCLES(B_BACK), .MAX_RETRIES(B_MAX)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .lock_req(b_lock), .unlock_req(b_unlock),
        .abort(b_abort), .granted(b_granted), .busy(b_busy), .lock_fail(b_lock_fail),
        .unlock_done(b_unlock_done), .retry_count(b_retry), .m_address(b_addr),
        .m_chipselect(b_cs), .m_read(b_rd), .m_write(b_wr), .m_writedata(b_wd),
        .m_readdata(b_rdata)
    );

    initial if (TB_LOCK_VALUE == 16'h0000) $fatal(1, "LOCK_VALUE must be nonzero");

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit addr_bad = 1'b0;
    int          a_wq_cyc[$];
    logic [31:0] a_wq_dat[$];
    int          a_rq[$];
    int          b_wq[$];
    int          b_rq[$];
    int          b_lf[$];

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Mutex accepts a write only when free or when the writer already owns it
    function automatic logic [31:0] mutex_write(input logic [31:0] cur, input logic [31:0] wd);
        if (cur[15:0] == 16'h0000 || cur[31:16] == wd[31:16]) return wd;
        return cur;
    endfunction

    task automatic clear_logs();
        a_wq_cyc.delete(); a_wq_dat.delete(); a_rq.delete();
        b_wq.delete(); b_rq.delete(); b_lf.delete();
    endtask

    // Called at posedge+1; logs this cycle's bus activity, then advances one cycle
    task automatic tick();
        bit          a_do, b_do;
        logic [31:0] a_d, b_d;
        a_do = a_cs && a_wr;  a_d = a_wd;
        b_do = b_cs && b_wr;  b_d = b_wd;
        if (a_do) begin a_wq_cyc.push_back(cyc); a_wq_dat.push_back(a_d); end
        if (a_cs && a_rd) a_rq.push_back(cyc);
        if (b_do) b_wq.push_back(cyc);
        if (b_cs && b_rd) b_rq.push_back(cyc);
        if (b_lock_fail) b_lf.push_back(cyc);
        if (a_addr !== 1'b0 || b_addr !== 1'b0) addr_bad = 1'b1;
        @(posedge clk);
        #1;
        if (a_do) mtx_a = mutex_write(mtx_a, a_d);
        if (b_do) mtx_b = mutex_write(mtx_b, b_d);
        cyc++;
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_a_granted"}, a_granted, 0);
        check({tag, "_a_busy"}, a_busy, 0);
        check({tag, "_a_lock_fail"}, a_lock_fail, 0);
        check({tag, "_a_unlock_done"}, a_unlock_done, 0);
        check({tag, "_a_retry"}, a_retry, 0);
        check({tag, "_a_bus"}, {a_addr, a_cs, a_rd, a_wr}, 0);
        check({tag, "_a_wdata"}, a_wd, 0);
    endtask

    task automatic check_zero_b(input string tag);
        check({tag, "_b_status"}, {b_granted, b_busy, b_lock_fail, b_unlock_done}, 0);
        check({tag, "_b_retry"}, b_retry, 0);
        check({tag, "_b_bus"}, {b_addr, b_cs, b_rd, b_wr}, 0);
        check({tag, "_b_wdata"}, b_wd, 0);
    endtask

    // Lock agent A after n contended attempts; the other owner frees the mutex after the n-th readback
    task automatic lock_run_a(input int n, input string tag);
        int c0;
        int per;
        bit rel;
        clear_logs();
        mtx_a = (n > 0) ? OTHER_HELD : 32'h0;
        per = A_BACK + 2;
        c0 = cyc;
        a_lock = 1'b1;
        a_unlock = (n == 0);
        tick();
        a_lock = 1'b0;
        a_unlock = 1'b0;
        check({tag, "_busy_in_wr"}, a_busy, 1);
        rel = 1'b0;
        for (int k = 0; k < 400 && a_granted !== 1'b1; k++) begin
            tick();
            if (n > 0 && !rel && a_rq.size() == n) begin
                mtx_a = OTHER_FREE;
                rel = 1'b1;
            end
        end
        check({tag, "_granted"}, a_granted, 1);
        check({tag, "_grant_cycle"}, cyc, c0 + 3 + n * per);
        check({tag, "_busy_held"}, a_busy, 0);
        check({tag, "_retry"}, a_retry, n);
        check({tag, "_writes"}, a_wq_cyc.size(), n + 1);
        check({tag, "_reads"}, a_rq.size(), n + 1);
        if (a_wq_cyc.size() == n + 1 && a_rq.size() == n + 1) begin
            for (int i = 0; i <= n; i++) begin
                check({tag, "_wr_cycle"}, a_wq_cyc[i], c0 + 1 + i * per);
                check({tag, "_wr_data"}, a_wq_dat[i], LOCK_WORD);
                check({tag, "_rd_cycle"}, a_rq[i], c0 + 2 + i * per);
            end
        end
        check({tag, "_mutex_owned"}, mtx_a, LOCK_WORD);
    endtask

    task automatic unlock_a(input string tag);
        int n0;
        clear_logs();
        n0 = cyc;
        a_unlock = 1'b1;
        tick();
        a_unlock = 1'b0;
        check({tag, "_busy_unl"}, a_busy, 1);
        check({tag, "_granted_unl"}, a_granted, 0);
        tick();
        check({tag, "_unlock_done"}, a_unlock_done, 1);
        check({tag, "_busy_idle"}, a_busy, 0);
        tick();
        check({tag, "_unlock_done_pulse"}, a_unlock_done, 0);
        check({tag, "_unl_writes"}, a_wq_cyc.size(), 1);
        if (a_wq_cyc.size() == 1) begin
            check({tag, "_unl_cycle"}, a_wq_cyc[0], n0 + 1);
            check({tag, "_unl_data"}, a_wq_dat[0], FREE_WORD);
        end
        check({tag, "_mutex_free"}, mtx_a, FREE_WORD);
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check_zero_a(tag);
        check_zero_b(tag);
        mtx_a = 32'h0;
        mtx_b = 32'h0;
        @(posedge clk);
        #1;
        cyc++;
        reset_n = 1'b1;
        clear_logs();
        repeat (3) tick();
        check({tag, "_quiet_after"}, a_wq_cyc.size() + a_rq.size(), 0);
        check({tag, "_busy_after"}, a_busy, 0);
    endtask

    initial begin
        int n;
        int c0;
        reset_n = 1'b0;
        {a_lock, a_unlock, a_abort, b_lock, b_unlock, b_abort} = '0;
        mtx_a = 32'h0;
        mtx_b = 32'h0;
        #12;
        check_zero_a("reset");
        check_zero_b("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) tick();

        // Free mutex, simultaneous unlock_req loses to lock_req
        lock_run_a(0, "t1");

        // lock_req while held causes no bus traffic; then release
        clear_logs();
        a_lock = 1'b1;
        tick();
        a_lock = 1'b0;
        repeat (3) tick();
        check("t4_held_no_traffic", a_wq_cyc.size() + a_rq.size(), 0);
        check("t4_still_granted", a_granted, 1);
        unlock_a("t4");
        clear_logs();
        a_unlock = 1'b1;
        tick();
        a_unlock = 1'b0;
        repeat (3) tick();
        check("t4_idle_unlock_ignored", a_wq_cyc.size() + a_rq.size(), 0);

        // Contended mutex released after a random number of failures
        n = 3;
        lock_run_a(n, "t2_fixed");
        unlock_a("t2_fixed_unl");
        repeat (2) begin
            n = $urandom_range(1, 4);
            repeat ($urandom_range(0, 3)) tick();
            lock_run_a(n, "t2_rand");
            unlock_a("t2_rand_unl");
        end

        // Retry limit exhausted on agent B
        clear_logs();
        mtx_b = OTHER_HELD;
        c0 = cyc;
        b_lock = 1'b1;
        tick();
        b_lock = 1'b0;
        for (int k = 0; k < 100 && b_lf.size() == 0; k++) tick();
        check("t3_lock_fail_seen", b_lf.size(), 1);
        if (b_lf.size() == 1)
            check("t3_lock_fail_cycle", b_lf[0], c0 + 1 + (B_MAX - 1) * (B_BACK + 2) + 2);
        check("t3_granted", b_granted, 0);
        check("t3_busy", b_busy, 0);
        check("t3_retry", b_retry, B_MAX);
        repeat (10) tick();
        check("t3_writes", b_wq.size(), B_MAX);
        check("t3_reads", b_rq.size(), B_MAX);
        check("t3_single_pulse", b_lf.size(), 1);
        if (b_wq.size() == B_MAX) begin
            check("t3_wr0_cycle", b_wq[0], c0 + 1);
            check("t3_wr1_cycle", b_wq[1], c0 + 1 + B_BACK + 2);
        end
        check("t3_retry_holds", b_retry, B_MAX);

        // Abort during backoff
        clear_logs();
        mtx_a = OTHER_HELD;
        a_lock = 1'b1;
        tick();
        a_lock = 1'b0;
        for (int k = 0; k < 50 && a_rq.size() < 1; k++) tick();
        check("t5_first_read", a_rq.size(), 1);
        repeat ($urandom_range(0, A_BACK - 1)) tick();
        check("t5_in_backoff", {a_busy, a_cs}, 2'b10);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("t5_busy", a_busy, 0);
        check("t5_granted", a_granted, 0);
        check("t5_lock_fail", a_lock_fail, 0);
        clear_logs();
        repeat (A_BACK + 3) tick();
        check("t5_no_more_writes", a_wq_cyc.size(), 0);

        // Abort during LOCK_RD with a matching readback still grants
        mtx_a = 32'h0;
        a_lock = 1'b1;
        tick();
        a_lock = 1'b0;
        tick();
        check("t5_rd_phase", {a_cs, a_rd}, 2'b11);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("t5_abort_rd_granted", a_granted, 1);
        check("t5_abort_rd_busy", a_busy, 0);
        unlock_a("t5_unl");

        // Reset during backoff, then during HELD
        clear_logs();
        mtx_a = OTHER_HELD;
        a_lock = 1'b1;
        tick();
        a_lock = 1'b0;
        for (int k = 0; k < 50 && a_rq.size() < 1; k++) tick();
        repeat ($urandom_range(0, 2)) tick();
        check("t6_retry_before", a_retry, 1);
        pulse_reset("t6_backoff");
        lock_run_a(0, "t6_relock");
        pulse_reset("t6_held");
        lock_run_a(0, "t6_relock2");
        unlock_a("t6_unl");

        check("m_address_never_set", addr_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mutex_lock_agent.md
Name: mutex_lock_agent

Overview:
- Hardware requester that acquires and releases one Avalon hardware mutex for a non-CPU client, e.g. a pixel-processing engine that shares a frame buffer with two NIOS cores.
- Sits directly upstream of the mutex peripheral: its master port drives the mutex slave's address, chipselect, read, write and write data, and consumes its read data.
- Runs the write-then-readback lock protocol, with fixed backoff and an optional retry limit, and exposes a simple request/grant interface to the client.

Parameters:
- OWNER_ID, 16'h0001: owner field written to mutex bits 31:16; unique per requester.
- LOCK_VALUE, 16'h0001: value field written on lock; must be nonzero. Zero is illegal, and the bench flags it at elaboration.
- BACKOFF_CYCLES, 16: idle cycles between a failed readback and the next write attempt; range 1..65535.
- MAX_RETRIES, 0: number of failed attempts before giving up; 0 means retry forever; range 0..255.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous, active-low reset.
- lock_req, in, 1: single-cycle request to acquire the mutex.
- unlock_req, in, 1: single-cycle request to release the mutex.
- abort, in, 1: cancels a lock attempt that is in progress.
- granted, out, 1: high while the mutex is held by this agent.
- busy, out, 1: high while any lock or unlock sequence is active.
- lock_fail, out, 1: one-cycle pulse when the retry limit is exhausted.
- unlock_done, out, 1: one-cycle pulse when the release write has been issued.
- retry_count, out, 8: failed attempts in the current lock sequence; saturates at 255.
- m_address, out, 1: mutex register select; 0 = mutex, 1 = reset flag.
- m_chipselect, out, 1: mutex slave select.
- m_read, out, 1: read strobe.
- m_write, out, 1: write strobe.
- m_writedata, out, 32: data to the mutex.
- m_readdata, in, 32: combinational read data from the mutex, valid in the same cycle as the read.

Behaviour:
- Reset: state = IDLE. All outputs are 0, including the master strobes and m_writedata. Retry and backoff counters clear.
- Reset mid-sequence: the agent returns to IDLE with no further bus activity. The mutex shares the same reset, so no unlock is attempted.
- Master outputs are decoded from the registered state only (Moore). m_address is always 0; the reset-flag register is never accessed. The slave has zero wait states and each access takes one cycle.
- Cycle at which m_readdata is sampled: the rising edge that ends the LOCK_RD cycle.
- IDLE:
  - lock_req=1 -> LOCK_WR and clear retry_count.
  - unlock_req is ignored.
  - If lock_req and unlock_req are both high, lock wins.
- LOCK_WR (1 cycle):
  - Drives cs=1, write=1, writedata={OWNER_ID,LOCK_VALUE}.
  - Next state is LOCK_RD.
  - busy=1 from this state through the end of the lock sequence.
- LOCK_RD (1 cycle):
  - Drives cs=1, read=1.
  - If m_readdata=={OWNER_ID,LOCK_VALUE} -> HELD.
  - Else, if MAX_RETRIES!=0 and retry_count+1==MAX_RETRIES -> IDLE, with lock_fail pulsed in the first IDLE cycle and retry_count holding its final value.
  - Else increment retry_count (saturating) -> BACKOFF, loading the backoff counter with BACKOFF_CYCLES-1.
- BACKOFF:
  - No bus activity.
  - Counter decrements each cycle; at 0 -> LOCK_WR.
  - The total gap from the end of LOCK_RD to the start of LOCK_WR is exactly BACKOFF_CYCLES cycles.
- abort:
  - Sampled in LOCK_WR, LOCK_RD and BACKOFF.
  - Forces the next state to IDLE, no lock_fail.
  - If abort arrives in LOCK_RD with a matching readback, HELD is entered instead, so the mutex is never silently left owned.
  - Ignored in IDLE, HELD and UNLOCK_WR.
- HELD:
  - granted=1, busy=0.
  - unlock_req -> UNLOCK_WR.
  - lock_req is ignored.
- UNLOCK_WR (1 cycle):
  - Drives cs=1, write=1, writedata={OWNER_ID,16'h0000}, granted=0, busy=1.
  - Next state is IDLE, with unlock_done pulsed in that IDLE cycle.
- Latency with an uncontended mutex: lock_req sampled at edge 0; LOCK_WR in cycle 1; LOCK_RD in cycle 2; granted high from cycle 3.
- Unlock latency: unlock_req sampled at edge N; write in cycle N+1; unlock_done in cycle N+2.
- Max-retry arithmetic: compare retry_count+1 at 9 bits, so the limit 255 works without wrap.

Test Plan:
1. Free mutex, OWNER_ID=1, LOCK_VALUE=1, lock_req pulse at cycle 0 -> write of 32'h00010001 in cycle 1, read in cycle 2, granted=1 from cycle 3, retry_count=0.
2. Mutex pre-held by owner 2 (value 32'h00020005), BACKOFF_CYCLES=4, MAX_RETRIES=0; release it after 3 failures -> writes spaced by 4 idle cycles; granted after the 4th write/readback; retry_count=3.
3. Mutex held by owner 2, MAX_RETRIES=2 -> exactly 2 write/read pairs, lock_fail single pulse, granted=0, retry_count=2, no further bus strobes.
4. While HELD, unlock_req -> one write of 32'h00010000; unlock_done pulse one cycle later; the mutex model reads value 0; a lock_req in HELD issued earlier caused no bus traffic.
5. Contended mutex; abort in BACKOFF -> IDLE next cycle, no lock_fail, busy=0. Abort in LOCK_RD with a matching readback -> granted=1.
6. reset_n asserted during BACKOFF and during HELD -> all outputs 0 immediately (asynchronously); after release the agent is IDLE, and a new lock_req succeeds with the cycle-3 latency.
